// File: rtl/uart_pkg.sv
// Shared UART definitions: ASCII constants, decimal frame FSM encoding and a
// BCD correction helper used by the shift-add-3 converter.
package uart_pkg;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    CONV,
    EMIT,
    WAIT_TX,
    SEP_B,
    CR_B,
    LF_B,
    DONE
  } frame_state_e;

  // Digits of 5 or more would overflow when doubled, so pre-add 3.
  function automatic logic [3:0] bcd_adjust(input logic [3:0] digit);
    return (digit >= 4'd5) ? (digit + 4'd3) : digit;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter. A byte starts on the rising edge of uart_tx_en and
// uart_tx_done pulses for one cycle at the end of the stop bit.
module uart_tx #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] uart_tx_data,
  input  logic       uart_tx_en,
  output logic       uart_tx_done,
  output logic       uart_txd
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic             en_d;
  logic             active;
  logic [8:0]       shreg;
  logic [3:0]       bit_cnt;
  logic [CNT_W-1:0] clk_cnt;

  // Edge-triggered start keeps an enable still held after done from re-sending.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      en_d         <= 1'b0;
      active       <= 1'b0;
      shreg        <= 9'h1FF;
      bit_cnt      <= 4'd0;
      clk_cnt      <= '0;
      uart_tx_done <= 1'b0;
      uart_txd     <= 1'b1;
    end else begin
      en_d         <= uart_tx_en;
      uart_tx_done <= 1'b0;
      if (!active) begin
        if (uart_tx_en && !en_d) begin
          active   <= 1'b1;
          shreg    <= {1'b1, uart_tx_data};
          bit_cnt  <= 4'd0;
          clk_cnt  <= '0;
          uart_txd <= 1'b0;
        end
      end else if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
        clk_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          active       <= 1'b0;
          uart_tx_done <= 1'b1;
        end else begin
          uart_txd <= shreg[0];
          shreg    <= {1'b1, shreg[8:1]};
          bit_cnt  <= bit_cnt + 4'd1;
        end
      end else begin
        clk_cnt <= clk_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_dec_frame_tx.sv
// Converts a frame of CH_NUM samples to decimal ASCII and sends it over UART
// as "ch0,ch1,...,chN\r\n", one byte per uart_tx handshake.
module uart_dec_frame_tx
  import uart_pkg::*;
#(
  parameter int         DATA_W      = 16,
  parameter int         CH_NUM      = 4,
  parameter int         DIGITS      = 5,
  parameter bit         SIGNED      = 1'b0,
  parameter bit         LZ_SUPPRESS = 1'b0,
  parameter logic [7:0] SEP         = 8'h2C
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic [CH_NUM*DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     uart_txd
);

  localparam int CH_W  = $clog2(CH_NUM) + 1;
  localparam int DIG_W = $clog2(DIGITS + 1);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int BCD_W = DIGITS * 4;

  frame_state_e state, state_next;

  logic [CH_NUM*DATA_W-1:0] frame_reg;
  logic [CH_W-1:0]          ch_idx;
  logic [DIG_W-1:0]         dig_cnt;
  logic [BIT_W-1:0]         bit_cnt;
  logic [BCD_W-1:0]         bcd_reg;
  logic [DATA_W-1:0]        mag_sr;
  logic                     neg;
  logic                     sign_pend;
  logic                     ovf;

  logic [7:0] uart_tx_data;
  logic       uart_tx_en;
  logic       uart_tx_done;

  logic [DATA_W-1:0] sample;
  logic [DATA_W:0]   mag;
  logic [BCD_W-1:0]  bcd_adj;
  logic [BCD_W-1:0]  bcd_shift;
  logic              ovf_next;
  logic [DIG_W-1:0]  nz_cnt;
  logic [DIG_W-1:0]  emit_cnt;
  logic [3:0]        cur_digit;
  logic              conv_last;
  logic              chars_left;
  logic              last_ch;
  logic              tx_ack;

  // Channel select and magnitude; DATA_W+1 bits keeps the most negative value exact.
  always_comb begin
    sample = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      if (ch_idx == CH_W'(c)) sample = frame_reg[c*DATA_W +: DATA_W];
    end
    if (SIGNED && sample[DATA_W-1]) mag = {1'b0, ~sample} + (DATA_W+1)'(1);
    else                            mag = {1'b0, sample};
  end

  // One shift-add-3 step; a carry out of the top digit means the value needs more than DIGITS digits.
  always_comb begin
    bcd_adj = '0;
    for (int d = 0; d < DIGITS; d++) begin
      bcd_adj[d*4 +: 4] = bcd_adjust(bcd_reg[d*4 +: 4]);
    end
    bcd_shift = {bcd_adj[BCD_W-2:0], mag_sr[DATA_W-1]};
    ovf_next  = ovf | bcd_adj[BCD_W-1];

    nz_cnt = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_shift[d*4 +: 4] != 4'd0) nz_cnt = DIG_W'(d + 1);
    end
    if (ovf_next || !LZ_SUPPRESS) emit_cnt = DIG_W'(DIGITS);
    else if (nz_cnt == '0)        emit_cnt = DIG_W'(1);
    else                          emit_cnt = nz_cnt;

    cur_digit = 4'd0;
    for (int d = 0; d < DIGITS; d++) begin
      if (dig_cnt == DIG_W'(d + 1)) cur_digit = bcd_reg[d*4 +: 4];
    end
    if (ovf) cur_digit = 4'd9;
  end

  assign conv_last  = (bit_cnt == BIT_W'(DATA_W - 1));
  assign chars_left = sign_pend || (dig_cnt != '0);
  assign last_ch    = (ch_idx == CH_W'(CH_NUM - 1));
  assign tx_ack     = uart_tx_en && uart_tx_done;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = LOAD;
      end
      LOAD:    state_next = CONV;
      CONV:    if (conv_last) state_next = EMIT;
      EMIT:    state_next = WAIT_TX;
      WAIT_TX: begin
        if (tx_ack) begin
          if (chars_left)   state_next = EMIT;
          else if (last_ch) state_next = CR_B;
          else              state_next = SEP_B;
        end
      end
      SEP_B:   if (tx_ack) state_next = LOAD;
      CR_B:    if (tx_ack) state_next = LF_B;
      LF_B:    if (tx_ack) state_next = DONE;
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath; the fixed-byte states drop uart_tx_en on the ack so the next state starts with it low.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_reg    <= '0;
      ch_idx       <= '0;
      dig_cnt      <= '0;
      bit_cnt      <= '0;
      bcd_reg      <= '0;
      mag_sr       <= '0;
      neg          <= 1'b0;
      sign_pend    <= 1'b0;
      ovf          <= 1'b0;
      uart_tx_data <= 8'h00;
      uart_tx_en   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            frame_reg <= in_data;
            ch_idx    <= '0;
          end
        end
        LOAD: begin
          mag_sr  <= mag[DATA_W-1:0];
          ovf     <= mag[DATA_W];
          neg     <= SIGNED && sample[DATA_W-1];
          bcd_reg <= '0;
          bit_cnt <= '0;
        end
        CONV: begin
          bcd_reg <= bcd_shift;
          mag_sr  <= mag_sr << 1;
          ovf     <= ovf_next;
          bit_cnt <= bit_cnt + BIT_W'(1);
          if (conv_last) begin
            dig_cnt   <= emit_cnt;
            sign_pend <= neg;
          end
        end
        EMIT: begin
          uart_tx_en <= 1'b1;
          if (sign_pend) begin
            uart_tx_data <= ASCII_MINUS;
            sign_pend    <= 1'b0;
          end else begin
            uart_tx_data <= ASCII_ZERO + {4'h0, cur_digit};
            dig_cnt      <= dig_cnt - DIG_W'(1);
          end
        end
        WAIT_TX: begin
          if (tx_ack) uart_tx_en <= 1'b0;
        end
        SEP_B: begin
          if (tx_ack) begin
            uart_tx_en <= 1'b0;
            ch_idx     <= ch_idx + CH_W'(1);
          end else begin
            uart_tx_en   <= 1'b1;
            uart_tx_data <= SEP;
          end
        end
        CR_B: begin
          if (tx_ack) begin
            uart_tx_en <= 1'b0;
          end else begin
            uart_tx_en   <= 1'b1;
            uart_tx_data <= ASCII_CR;
          end
        end
        LF_B: begin
          if (tx_ack) begin
            uart_tx_en <= 1'b0;
          end else begin
            uart_tx_en   <= 1'b1;
            uart_tx_data <= ASCII_LF;
          end
        end
        default: ;
      endcase
    end
  end

  uart_tx u_uart_tx (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .uart_tx_data (uart_tx_data),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_done (uart_tx_done),
    .uart_txd     (uart_txd)
  );

endmodule

// File: tb/tb_uart_dec_frame_tx.sv
// Bench for uart_dec_frame_tx: four parameter variants share one decoded serial
// line; only one is active at a time, so their txd outputs are ANDed together.
module tb_uart_dec_frame_tx;

  localparam int BIT_CLKS = 8;
  localparam int FRAME_BUDGET = 6000;
  localparam int NV = 8;

  typedef struct packed {
    logic [1:0]   inst;
    logic [63:0]  data;
    logic [255:0] exp;
    logic [7:0]   len;
  } vec_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [63:0] in_data = '0;
  logic [3:0]  vld = '0;
  wire  [3:0]  rdy, bsy, fdn, txd;
  wire         txd_all = &txd;

  int          n_checks = 0;
  int          n_fail = 0;
  int          fd_count = 0;
  logic [7:0]  rxq[$];
  vec_t        vecs [NV];

  always #5 sys_clk = ~sys_clk;

  uart_dec_frame_tx u0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_data(in_data), .in_valid(vld[0]),
    .in_ready(rdy[0]), .busy(bsy[0]), .frame_done(fdn[0]), .uart_txd(txd[0]));

  uart_dec_frame_tx #(.LZ_SUPPRESS(1'b1)) u1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_data(in_data), .in_valid(vld[1]),
    .in_ready(rdy[1]), .busy(bsy[1]), .frame_done(fdn[1]), .uart_txd(txd[1]));

  uart_dec_frame_tx #(.SIGNED(1'b1), .LZ_SUPPRESS(1'b1), .DATA_W(16)) u2 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_data(in_data), .in_valid(vld[2]),
    .in_ready(rdy[2]), .busy(bsy[2]), .frame_done(fdn[2]), .uart_txd(txd[2]));

  uart_dec_frame_tx #(.DIGITS(3)) u3 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_data(in_data), .in_valid(vld[3]),
    .in_ready(rdy[3]), .busy(bsy[3]), .frame_done(fdn[3]), .uart_txd(txd[3]));

  always @(negedge sys_clk) fd_count <= fd_count + $countones(fdn);

  // 8N1 receiver sampling mid-bit on the falling clock edge.
  initial begin : rx_mon
    logic [7:0] b;
    forever begin
      @(negedge txd_all);
      repeat (BIT_CLKS/2) @(negedge sys_clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BIT_CLKS) @(negedge sys_clk);
        b[i] = txd_all;
      end
      repeat (BIT_CLKS) @(negedge sys_clk);
      rxq.push_back(b);
    end
  end

  initial begin
    #1500000;
    $display("[TB] FAIL global_timeout: simulation time exceeded");
    $fatal(1, "[TB] global timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] inst, input logic [63:0] data,
                              input logic [255:0] exp, input int len);
    vec_t v;
    v.inst = inst;
    v.data = data;
    v.exp  = exp;
    v.len  = 8'(len);
    return v;
  endfunction

  task automatic applyStimulus(input int inst, input logic [63:0] data);
    int n = 0;
    @(negedge sys_clk);
    in_data   = data;
    vld[inst] = 1'b1;
    while (!rdy[inst] && n < FRAME_BUDGET) begin
      @(negedge sys_clk);
      n++;
    end
    check("handshake_ready", 64'(rdy[inst]), 64'd1);
    @(negedge sys_clk);
    vld[inst] = 1'b0;
    check("busy_after_accept", 64'(bsy[inst]), 64'd1);
  endtask

  task automatic waitFrames(input int target);
    int n = 0;
    while (fd_count < target && n < 2 * FRAME_BUDGET) begin
      @(negedge sys_clk);
      n++;
    end
    if (fd_count < target) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL frame_timeout: actual=%0d required=%0d frame_done pulses", fd_count, target);
    end
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic checkOutput(input string name, input logic [511:0] exp, input int len,
                             input int fd_start, input int nframes, input int inst);
    check({name, "_len"}, 64'(rxq.size()), 64'(len));
    for (int i = 0; i < len && i < rxq.size(); i++) begin
      check($sformatf("%s_byte%0d", name, i), 64'(rxq[i]), 64'(exp[(len-1-i)*8 +: 8]));
    end
    check({name, "_frame_done"}, 64'(fd_count - fd_start), 64'(nframes));
    check({name, "_idle_busy"}, 64'(bsy[inst]), 64'd0);
    check({name, "_idle_ready"}, 64'(rdy[inst]), 64'd1);
    rxq.delete();
  endtask

  initial begin
    int fd_start;
    int n;

    vecs[0] = mk(0, {16'd65535, 16'd12345, 16'd7, 16'd0}, "00000,00007,12345,65535\r\n", 25);
    vecs[1] = mk(1, {16'd65535, 16'd12345, 16'd7, 16'd0}, "0,7,12345,65535\r\n", 17);
    vecs[2] = mk(2, {16'h7FFF, 16'h0000, 16'hFFFF, 16'h8000}, "-32768,-1,0,32767\r\n", 19);
    vecs[3] = mk(3, {16'd5, 16'd5, 16'd5, 16'd1000}, "999,005,005,005\r\n", 17);
    vecs[4] = mk(0, {16'd100, 16'd40000, 16'd9, 16'd1}, "00001,00009,40000,00100\r\n", 25);
    vecs[5] = mk(1, {16'd10, 16'd0, 16'd100, 16'd0}, "0,100,0,10\r\n", 12);
    vecs[6] = mk(2, {16'hFFF6, 16'h000A, 16'h8001, 16'h0001}, "1,-32767,10,-10\r\n", 17);
    vecs[7] = mk(3, {16'd999, 16'd65535, 16'd0, 16'd42}, "042,000,999,999\r\n", 17);

    repeat (3) @(negedge sys_clk);
    check("rst_busy", 64'(bsy), 64'h0);
    check("rst_frame_done", 64'(fdn), 64'h0);
    check("rst_tx_en", 64'(u0.uart_tx_en), 64'h0);
    check("rst_tx_data", 64'(u0.uart_tx_data), 64'h0);
    check("rst_txd", 64'(txd), 64'hF);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("ready_after_release", 64'(rdy), 64'hF);

    for (int v = 0; v < NV; v++) begin
      fd_start = fd_count;
      applyStimulus(int'(vecs[v].inst), vecs[v].data);
      waitFrames(fd_start + 1);
      checkOutput($sformatf("vec%0d", v), 512'(vecs[v].exp), int'(vecs[v].len), fd_start, 1,
                  int'(vecs[v].inst));
    end

    // in_valid held across two frames; in_data changed mid-frame must not leak in.
    fd_start = fd_count;
    @(negedge sys_clk);
    in_data = {16'd3000, 16'd300, 16'd30, 16'd3};
    vld[0]  = 1'b1;
    n = 0;
    while (rdy[0] && n < 10) begin
      @(negedge sys_clk);
      n++;
    end
    in_data = {16'd11111, 16'd22222, 16'd33333, 16'd44444};
    repeat (200) @(negedge sys_clk);
    check("b2b_held_off_ready", 64'(rdy[0]), 64'd0);
    check("b2b_held_off_busy", 64'(bsy[0]), 64'd1);
    n = 0;
    while (!fdn[0] && n < FRAME_BUDGET) begin
      @(negedge sys_clk);
      n++;
    end
    check("b2b_first_done", 64'(fdn[0]), 64'd1);
    in_data = {16'd22, 16'd1, 16'd0, 16'd54321};
    @(negedge sys_clk);
    check("b2b_second_ready", 64'(rdy[0]), 64'd1);
    @(negedge sys_clk);
    vld[0]  = 1'b0;
    in_data = '0;
    waitFrames(fd_start + 2);
    checkOutput("b2b", {"00003,00030,00300,03000\r\n", "54321,00000,00001,00022\r\n"}, 50,
                fd_start, 2, 0);

    // Reset pulsed while the second channel's digits are going out.
    applyStimulus(0, {16'd4444, 16'd333, 16'd22, 16'd1});
    n = 0;
    while (rxq.size() < 7 && n < FRAME_BUDGET) begin
      @(negedge sys_clk);
      n++;
    end
    check("rst_mid_progress", 64'(rxq.size() >= 7), 64'd1);
    sys_rst_n = 1'b0;
    #1;
    check("rst_mid_tx_en", 64'(u0.uart_tx_en), 64'd0);
    check("rst_mid_busy", 64'(bsy[0]), 64'd0);
    check("rst_mid_txd", 64'(txd[0]), 64'd1);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("rst_mid_ready", 64'(rdy[0]), 64'd1);
    repeat (150) @(negedge sys_clk);
    rxq.delete();
    fd_start = fd_count;
    repeat (300) @(negedge sys_clk);
    check("rst_quiet_bytes", 64'(rxq.size()), 64'd0);
    check("rst_quiet_tx_en", 64'(u0.uart_tx_en), 64'd0);
    check("rst_quiet_frame_done", 64'(fd_count - fd_start), 64'd0);

    fd_start = fd_count;
    applyStimulus(0, vecs[0].data);
    waitFrames(fd_start + 1);
    checkOutput("after_rst", 512'(vecs[0].exp), int'(vecs[0].len), fd_start, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_dec_frame_tx.md
UART_DEC_FRAME_TX -- requirements
Module: uart_dec_frame_tx

Interface
REQ-001 The block SHALL use clock sys_clk and reset sys_rst_n, asynchronous, active-low.
REQ-002 The block SHALL have these parameters:
- DATA_W, default 16: sample width in bits.
- CH_NUM, default 4: channels per frame.
- DIGITS, default 5: decimal digit field width.
- SIGNED, default 0: 1 treats samples as two's complement.
- LZ_SUPPRESS, default 0: 1 drops leading zeros.
- SEP, default 8'h2C: separator byte between channels.
REQ-003 The block SHALL have these ports:
- sys_clk  in  1  clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- in_data  in  CH_NUM*DATA_W  samples; channel 0 in the LSBs.
- in_valid  in  1  frame offered.
- in_ready  out  1  frame accepted when high together with in_valid.
- busy  out  1  a frame is in progress.
- frame_done  out  1  one-cycle pulse after the last byte is sent.
- uart_txd  out  1  serial line.

Function
REQ-004 in_ready SHALL be high only in IDLE; the handshake SHALL capture all of in_data into an internal frame register.
REQ-005 in_data changes after the handshake SHALL NOT affect the frame in progress.
REQ-006 The FSM SHALL have states IDLE, LOAD, CONV, EMIT, WAIT_TX, SEP_B, CR_B, LF_B, DONE.
REQ-007 FSM transitions SHALL be:
- IDLE->LOAD on handshake.
- LOAD->CONV.
- CONV->EMIT after exactly DATA_W cycles.
- EMIT->WAIT_TX.
- WAIT_TX->EMIT while characters remain in the current channel.
- Otherwise WAIT_TX->SEP_B if channel < CH_NUM-1, else WAIT_TX->CR_B.
- SEP_B->LOAD for the next channel.
- CR_B->LF_B.
- LF_B->DONE.
- DONE->IDLE.
REQ-008 The LOAD state SHALL select the channel and form its magnitude. When SIGNED=1 and the sample MSB is 1, it SHALL take the two's-complement magnitude in DATA_W+1 bits so that the most negative value is exact, and it SHALL set a neg flag.
REQ-009 CONV SHALL use iterative shift-add-3 binary-to-BCD conversion into a DIGITS*4-bit register, one input bit per cycle; the conversion SHALL NOT use division.
REQ-010 If the magnitude is at least 10^DIGITS, the channel SHALL emit DIGITS '9' characters (saturation), with the sign preserved.
REQ-011 Channel character order SHALL be:
- '-' (8'h2D) if neg.
- Then the digits, most significant first, each as 8'h30+digit.
REQ-012 When LZ_SUPPRESS=1, leading zero digits SHALL be skipped; a zero value SHALL emit a single '0', and no '-' SHALL be emitted for zero.
REQ-013 Frame byte order SHALL be:
- ch0 characters, SEP, ch1 characters, ..., ch(CH_NUM-1) characters.
- Then 8'h0D, then 8'h0A.
- No SEP after the last channel.
REQ-014 Every byte SHALL be sent through uart_tx as follows:
- uart_tx_data SHALL be stable and uart_tx_en high from the cycle the byte is issued until uart_tx_done is sampled high.
- uart_tx_en SHALL be low for at least one cycle between bytes.
REQ-015 The cycle after uart_tx_done, the block SHALL advance exactly one byte; a uart_tx_done seen outside a byte-wait state SHALL be ignored.
REQ-016 busy SHALL be high in every state except IDLE.
REQ-017 frame_done SHALL be high only in DONE.
REQ-018 in_valid asserted during busy SHALL be held off (in_ready=0) and SHALL be accepted in the first IDLE cycle; no frame SHALL be dropped or merged.
REQ-019 Counters SHALL be sized to these widths:
- Channel index: $clog2(CH_NUM)+1 bits.
- Digit index: $clog2(DIGITS+1) bits.
- Conversion bit counter: $clog2(DATA_W+1) bits.

Reset
REQ-020 Reset SHALL force:
- State IDLE; in_ready=1 from the first cycle after reset release.
- busy=0, frame_done=0.
- uart_tx_en=0, uart_tx_data=8'h00.
- All counters, the BCD register and the frame register to 0.
REQ-021 Reset asserted mid-frame SHALL abort the frame at once; no further bytes SHALL be issued after release until a new handshake.

Structure
REQ-022 The ASCII constants (CR 8'h0D, LF 8'h0A, MINUS 8'h2D, ZERO 8'h30) and the state encoding SHALL live in the shared package uart_pkg.
REQ-023 The block SHALL instantiate the existing uart_tx as its only sub-module, with ports sys_clk, sys_rst_n, uart_tx_data, uart_tx_en, uart_tx_done and uart_txd.
REQ-024 The BCD converter SHALL be inline logic, not a separate module.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Defaults, ch0..3 = 0, 7, 12345, 65535 -> bytes "00000,00007,12345,65535\r\n"; one frame_done pulse.
- LZ_SUPPRESS=1, same data -> "0,7,12345,65535\r\n".
- SIGNED=1, LZ_SUPPRESS=1, DATA_W=16, ch0..3 = 16'h8000, 16'hFFFF, 0, 16'h7FFF -> "-32768,-1,0,32767\r\n".
- DIGITS=3, ch0=1000, ch1..3=5 -> "999,005,005,005\r\n".
- in_valid held through two frames -> two complete back-to-back frames; the second in_data is captured only at the second in_ready cycle.
- Reset pulsed during the second channel's digits -> uart_tx_en is low and busy=0 immediately; the next frame is sent complete and correct.
